// File: rtl/tpsram_stream_reader_pkg.sv
// Shared widths and Gray/binary pointer helpers for the two-port SRAM buffer controllers.
package tpsram_reader_pkg;

    localparam int ADDR_W = 9;
    localparam int DATA_W = 32;
    localparam int PTR_W  = ADDR_W + 1;

    typedef logic [PTR_W-1:0] ptr_t;

    function automatic ptr_t bin2gray(input ptr_t b);
        return b ^ (b >> 1);
    endfunction

    function automatic ptr_t gray2bin(input ptr_t g);
        ptr_t b;
        b[PTR_W-1] = g[PTR_W-1];
        for (int i = PTR_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/tpsram_stream_reader_if.sv
// Output stream towards the LVDS serializer.
// A word transfers on every RCLK edge where DOUT_VALID && DOUT_READY; while VALID is high and READY low, DOUT/DOUT_LAST hold.
interface tpsram_stream_reader_if
    import tpsram_reader_pkg::*;
#(
    parameter int DW = DATA_W
);
    logic [DW-1:0] DOUT;
    logic          DOUT_VALID;
    logic          DOUT_READY;
    logic          DOUT_LAST;

    modport master (output DOUT, output DOUT_VALID, output DOUT_LAST, input DOUT_READY);
    modport slave  (input DOUT, input DOUT_VALID, input DOUT_LAST, output DOUT_READY);
endinterface

// File: rtl/tpsram_stream_reader_sync.sv
// Gray pointer synchronizer: SYNC_STAGES flops, then a registered Gray-to-binary conversion.
module tpsram_gray_sync
    import tpsram_reader_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  ptr_t gray_i,
    output ptr_t bin_o
);

    logic [SYNC_STAGES-1:0][PTR_W-1:0] sync_q;
    ptr_t                              bin_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
            bin_q  <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], gray_i};
            bin_q  <= gray2bin(sync_q[SYNC_STAGES-1]);
        end
    end

    assign bin_o = bin_q;

endmodule

// File: rtl/tpsram_stream_reader.sv
// Read-side controller of the 32x512 two-port SRAM buffer: pointer sync, read issue,
// 2-entry skid buffer absorbing the SRAM read latency, and frame-end marking.
module tpsram_stream_reader
    import tpsram_reader_pkg::*;
#(
    parameter int FRAME_WORDS = 64,
    parameter int SYNC_STAGES = 2
) (
    input  logic                RCLK,
    input  logic                RESET_N,
    input  ptr_t                WPTR_GRAY,
    output ptr_t                RPTR_GRAY,
    output logic [ADDR_W-1:0]   RADDR,
    input  logic [DATA_W-1:0]   RD,
    input  logic                FLUSH,
    output logic                EMPTY,
    output ptr_t                LEVEL,
    tpsram_stream_reader_if.master dout_if
);

    localparam int              FC_W    = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
    localparam logic [FC_W-1:0] FC_LAST = FC_W'(FRAME_WORDS - 1);

    ptr_t              wbin;
    ptr_t              rbin_q, rbin_d;
    ptr_t              rptr_gray_q;
    logic              infl_q, infl_d;
    logic [DATA_W-1:0] ent0_q, ent0_d, ent1_q, ent1_d;
    logic              vld0_q, vld0_d, vld1_q, vld1_d;
    logic [FC_W-1:0]   fcnt_q, fcnt_d;
    logic              last_q, last_d;
    logic              empty, pop, cap, issue;
    logic [1:0]        occ;

    tpsram_gray_sync #(.SYNC_STAGES(SYNC_STAGES)) u_wptr_sync (
        .clk_i  (RCLK),
        .rst_ni (RESET_N),
        .gray_i (WPTR_GRAY),
        .bin_o  (wbin)
    );

    assign empty = (wbin == rbin_q);
    assign pop   = vld0_q & dout_if.DOUT_READY & ~FLUSH;
    assign cap   = infl_q & ~FLUSH;
    // Occupancy after this edge's pop and capture; issuing on it keeps 1 word/cycle under READY.
    assign occ   = {1'b0, vld0_q} + {1'b0, vld1_q} + {1'b0, infl_q} - {1'b0, pop};
    assign issue = ~FLUSH & ~empty & (occ < 2'd2);

    always_comb begin
        rbin_d = rbin_q;
        infl_d = issue;
        ent0_d = ent0_q;
        ent1_d = ent1_q;
        vld0_d = vld0_q;
        vld1_d = vld1_q;
        fcnt_d = fcnt_q;
        if (pop) begin
            ent0_d = ent1_q;
            vld0_d = vld1_q;
            vld1_d = 1'b0;
            fcnt_d = (fcnt_q == FC_LAST) ? '0 : fcnt_q + FC_W'(1);
        end
        if (cap) begin
            if (!vld0_d) begin
                ent0_d = RD;
                vld0_d = 1'b1;
            end else begin
                ent1_d = RD;
                vld1_d = 1'b1;
            end
        end
        if (issue) begin
            rbin_d = rbin_q + PTR_W'(1);
        end
        if (FLUSH) begin
            rbin_d = wbin;
            vld0_d = 1'b0;
            vld1_d = 1'b0;
            fcnt_d = '0;
        end
        last_d = (fcnt_d == FC_LAST);
    end

    always_ff @(posedge RCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            rbin_q      <= '0;
            rptr_gray_q <= '0;
            infl_q      <= 1'b0;
            ent0_q      <= '0;
            ent1_q      <= '0;
            vld0_q      <= 1'b0;
            vld1_q      <= 1'b0;
            fcnt_q      <= '0;
            last_q      <= 1'b0;
        end else begin
            rbin_q      <= rbin_d;
            rptr_gray_q <= bin2gray(rbin_d);
            infl_q      <= infl_d;
            ent0_q      <= ent0_d;
            ent1_q      <= ent1_d;
            vld0_q      <= vld0_d;
            vld1_q      <= vld1_d;
            fcnt_q      <= fcnt_d;
            last_q      <= last_d;
        end
    end

    assign RPTR_GRAY          = rptr_gray_q;
    assign RADDR              = rbin_q[ADDR_W-1:0];
    assign EMPTY              = empty;
    assign LEVEL              = wbin - rbin_q;
    assign dout_if.DOUT       = ent0_q;
    assign dout_if.DOUT_VALID = vld0_q;
    assign dout_if.DOUT_LAST  = vld0_q & last_q;

endmodule

// File: tb/tb_tpsram_stream_reader.sv
// Bench for tpsram_stream_reader: SRAM and writer models, FIFO word model with frame counting.
module tb_tpsram_stream_reader;
  import tpsram_reader_pkg::*;

  localparam int FW = 4;

  logic              RCLK = 1'b0;
  logic              RESET_N;
  ptr_t              WPTR_GRAY, RPTR_GRAY, LEVEL;
  logic [ADDR_W-1:0] RADDR;
  logic [DATA_W-1:0] RD;
  logic              FLUSH, EMPTY;

  tpsram_stream_reader_if s_if ();

  tpsram_stream_reader #(.FRAME_WORDS(FW), .SYNC_STAGES(2)) dut (
    .RCLK      (RCLK),
    .RESET_N   (RESET_N),
    .WPTR_GRAY (WPTR_GRAY),
    .RPTR_GRAY (RPTR_GRAY),
    .RADDR     (RADDR),
    .RD        (RD),
    .FLUSH     (FLUSH),
    .EMPTY     (EMPTY),
    .LEVEL     (LEVEL),
    .dout_if   (s_if)
  );

  always #5 RCLK = ~RCLK;

  logic [DATA_W-1:0] sram [512];
  always @(posedge RCLK) RD <= sram[RADDR];

  int                n_assert = 0;
  int                n_fail = 0;
  logic [DATA_W-1:0] exp_q[$];
  int                hs_cnt, hs_total;
  int                last_pos[$];
  logic [ADDR_W-1:0] raddr_log[$];
  logic [9:0]        wptr;
  logic              hold_pending;
  logic [DATA_W-1:0] held;

  function automatic ptr_t to_gray(input ptr_t b);
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [31:0] d);
    sram[wptr[8:0]] = d;
    exp_q.push_back(d);
    wptr = wptr + 10'd1;
    WPTR_GRAY = to_gray(wptr);
  endtask

  function automatic logic [31:0] pat(input logic [9:0] p);
    return 32'hA000_0000 | {23'd0, p[8:0]};
  endfunction

  // Check the transfer about to happen at the next edge, then advance one clock.
  task automatic tick();
    logic [31:0] e;
    if (hold_pending) begin
      chk("hold_valid", s_if.DOUT_VALID, 1);
      chk("hold_data", s_if.DOUT, held);
    end
    if (s_if.DOUT_VALID && s_if.DOUT_READY && !FLUSH) begin
      hs_total++;
      if (exp_q.size() == 0) begin
        chk("spurious_word", s_if.DOUT_VALID, 0);
      end else begin
        e = exp_q.pop_front();
        chk("word_data", s_if.DOUT, e);
        chk("word_last", s_if.DOUT_LAST, (hs_cnt % FW) == FW - 1);
        if (s_if.DOUT_LAST) last_pos.push_back(hs_total);
        hs_cnt++;
      end
    end
    hold_pending = s_if.DOUT_VALID && !s_if.DOUT_READY && !FLUSH;
    held = s_if.DOUT;
    if (FLUSH) begin
      exp_q.delete();
      hs_cnt = 0;
    end
    @(posedge RCLK);
    #1;
    if (raddr_log.size() == 0 || RADDR != raddr_log[$]) raddr_log.push_back(RADDR);
  endtask

  task automatic drain(input int max_cycles);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < max_cycles) begin
      tick();
      n++;
    end
    chk("drain_done", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    RESET_N = 1'b0;
    FLUSH = 1'b0;
    s_if.DOUT_READY = 1'b0;
    wptr = '0;
    WPTR_GRAY = '0;
    exp_q.delete();
    hs_cnt = 0;
    hs_total = 0;
    hold_pending = 1'b0;
    repeat (2) @(posedge RCLK);
    #1;
    RESET_N = 1'b1;
  endtask

  initial begin
    RESET_N = 1'b0;
    FLUSH = 1'b0;
    s_if.DOUT_READY = 1'b0;
    wptr = '0;
    WPTR_GRAY = '0;
    hs_cnt = 0;
    hs_total = 0;
    hold_pending = 1'b0;
    held = '0;
    for (int a = 0; a < 512; a++) sram[a] = 32'hA000_0000 | 32'(a);

    // Reset values
    #1;
    chk("rst_rptr", RPTR_GRAY, 0);
    chk("rst_raddr", RADDR, 0);
    chk("rst_dout", s_if.DOUT, 0);
    chk("rst_valid", s_if.DOUT_VALID, 0);
    chk("rst_last", s_if.DOUT_LAST, 0);
    chk("rst_empty", EMPTY, 1);
    chk("rst_level", LEVEL, 0);

    // Latency and back-to-back delivery of 4 words
    do_reset();
    s_if.DOUT_READY = 1'b1;
    for (int e = 0; e < 8; e++) begin
      if (e < 4) wr(pat(wptr));
      tick();
      chk("latency_valid", s_if.DOUT_VALID, (e >= 4));
    end
    tick();
    chk("lat_end_valid", s_if.DOUT_VALID, 0);
    chk("lat_end_empty", EMPTY, 1);
    chk("lat_end_level", LEVEL, 0);
    chk("lat_model_empty", exp_q.size(), 0);

    // Backpressure: only 2 words leave the SRAM during the stall
    do_reset();
    for (int i = 0; i < 10; i++) begin
      wr(pat(wptr));
      tick();
    end
    repeat (10) tick();
    chk("bp_raddr", RADDR, 2);
    chk("bp_level", LEVEL, 8);
    chk("bp_valid", s_if.DOUT_VALID, 1);
    chk("bp_dout", s_if.DOUT, 32'hA000_0000);
    s_if.DOUT_READY = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chk("bp_nogap", s_if.DOUT_VALID, 1);
      tick();
    end
    chk("bp_model_empty", exp_q.size(), 0);
    chk("bp_end_valid", s_if.DOUT_VALID, 0);

    // Pointer wrap: read pointer moved to 1020 via FLUSH
    do_reset();
    wptr = 10'd1020;
    WPTR_GRAY = to_gray(wptr);
    repeat (4) tick();
    FLUSH = 1'b1;
    tick();
    FLUSH = 1'b0;
    chk("wrap_start_raddr", RADDR, 508);
    chk("wrap_start_empty", EMPTY, 1);
    raddr_log.delete();
    raddr_log.push_back(RADDR);
    s_if.DOUT_READY = 1'b1;
    for (int i = 0; i < 8; i++) begin
      wr(pat(wptr));
      tick();
    end
    drain(50);
    repeat (3) tick();
    chk("wrap_log_size", raddr_log.size(), 9);
    for (int i = 0; i < 8 && i < raddr_log.size(); i++) begin
      chk("wrap_raddr_seq", raddr_log[i], (508 + i) % 512);
    end
    chk("wrap_rptr_gray", RPTR_GRAY, to_gray(10'd4));

    // Frame marking with READY toggling
    do_reset();
    last_pos.delete();
    for (int i = 0; i < 80; i++) begin
      if (i < 10) wr(pat(wptr));
      s_if.DOUT_READY = (i % 2 == 0);
      tick();
      if (i >= 10 && exp_q.size() == 0) break;
    end
    chk("frame_drained", exp_q.size(), 0);
    chk("frame_last_count", last_pos.size(), 2);
    if (last_pos.size() == 2) begin
      chk("frame_last_first", last_pos[0], 4);
      chk("frame_last_second", last_pos[1], 8);
    end

    // FLUSH with one word buffered, one in flight, LEVEL=5
    do_reset();
    s_if.DOUT_READY = 1'b1;
    for (int i = 0; i < 7; i++) wr(pat(wptr));
    repeat (5) tick();
    chk("fl_pre_level", LEVEL, 5);
    chk("fl_pre_valid", s_if.DOUT_VALID, 1);
    FLUSH = 1'b1;
    tick();
    FLUSH = 1'b0;
    chk("fl_valid", s_if.DOUT_VALID, 0);
    chk("fl_empty", EMPTY, 1);
    chk("fl_level", LEVEL, 0);
    chk("fl_rptr", RPTR_GRAY, to_gray(10'd7));
    tick();
    chk("fl_inflight_dropped", s_if.DOUT_VALID, 0);
    for (int i = 0; i < 4; i++) begin
      wr(pat(wptr));
      tick();
    end
    drain(40);

    // Asynchronous reset mid-burst
    do_reset();
    s_if.DOUT_READY = 1'b1;
    for (int i = 0; i < 12; i++) begin
      wr(pat(wptr));
      tick();
    end
    chk("mr_pre_valid", s_if.DOUT_VALID, 1);
    #2;
    RESET_N = 1'b0;
    #1;
    chk("mr_rptr", RPTR_GRAY, 0);
    chk("mr_raddr", RADDR, 0);
    chk("mr_dout", s_if.DOUT, 0);
    chk("mr_valid", s_if.DOUT_VALID, 0);
    chk("mr_last", s_if.DOUT_LAST, 0);
    chk("mr_empty", EMPTY, 1);
    chk("mr_level", LEVEL, 0);
    wptr = '0;
    WPTR_GRAY = '0;
    exp_q.delete();
    hs_cnt = 0;
    hold_pending = 1'b0;
    repeat (2) @(posedge RCLK);
    #1;
    RESET_N = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("mr_no_stale_valid", s_if.DOUT_VALID, 0);
    end

    // Randomized traffic against the FIFO model
    do_reset();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 1) == 1 && exp_q.size() < 300) wr($urandom);
      s_if.DOUT_READY = ($urandom_range(0, 3) != 0);
      tick();
    end
    s_if.DOUT_READY = 1'b1;
    drain(800);
    repeat (4) tick();
    chk("rand_end_empty", EMPTY, 1);
    chk("rand_end_level", LEVEL, 0);
    chk("rand_end_valid", s_if.DOUT_VALID, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/tpsram_stream_reader.md
Name: tpsram_stream_reader

Overview:
- Read-side controller for the 32x512 two-port SRAM buffer in the LVDS path.
- Tracks the write-side Gray pointer and drives RADDR on the SRAM read port.
- Absorbs the one-cycle read latency in a 2-entry skid buffer and presents a valid/ready 32-bit stream to the LVDS transmit serializer, marking frame ends with DOUT_LAST.
- Returns its own Gray read pointer to the write-side controller for full detection.

Parameters:
- ADDR_W, 9, SRAM address width (512 words); pointers are ADDR_W+1 bits including the wrap bit.
- DATA_W, 32, word width; matches RD.
- FRAME_WORDS, 64, words per frame; DOUT_LAST marks word FRAME_WORDS-1. Legal range 2..65535.
- SYNC_STAGES, 2, flop stages for WPTR_GRAY synchronization. Minimum 2.

Ports:
- RCLK  in  1  read clock; same clock that drives the SRAM read port.
- RESET_N  in  1  asynchronous active-low reset.
- WPTR_GRAY  in  ADDR_W+1  write pointer, Gray-coded, from the write clock domain.
- RPTR_GRAY  out  ADDR_W+1  read pointer, Gray-coded, registered; sent to the write domain.
- RADDR  out  ADDR_W  SRAM read address.
- RD  in  DATA_W  SRAM read data; valid the cycle after RADDR is sampled.
- DOUT  out  DATA_W  stream data.
- DOUT_VALID  out  1  stream valid.
- DOUT_READY  in  1  stream ready.
- DOUT_LAST  out  1  last word of a frame; qualified by DOUT_VALID.
- FLUSH  in  1  synchronous discard of all buffered and unread data.
- EMPTY  out  1  synchronized write pointer equals the read pointer.
- LEVEL  out  ADDR_W+1  unread words in the SRAM, range 0..512.

Behaviour:
- Reset (asynchronous on RESET_N low, released synchronously):
  - RPTR_GRAY=0, RADDR=0, DOUT=0, DOUT_VALID=0, DOUT_LAST=0, EMPTY=1, LEVEL=0.
  - Synchronizer flops, skid buffer, in-flight flag and frame counter all cleared.
- Pointer synchronization:
  - WPTR_GRAY passes through SYNC_STAGES flops, then is converted to binary (wbin).
  - The read pointer rbin is held in binary; RPTR_GRAY is registered as bin2gray(rbin).
- Status outputs:
  - EMPTY = (wbin == rbin), including the wrap bit.
  - LEVEL = (wbin - rbin) mod 2^(ADDR_W+1).
- Read issue:
  - Condition: !EMPTY and (buffered words + in-flight read) < 2.
  - RADDR = rbin[ADDR_W-1:0]; rbin increments at the issuing edge; the in-flight flag is set.
  - At most one read is in flight.
  - rbin wraps from 1023 to 0; RADDR wraps from 511 to 0.
- Data capture:
  - RD is written into the skid buffer at the edge after issue.
  - The buffer is FIFO-ordered; DOUT/DOUT_VALID/DOUT_LAST come from the head entry and are registered.
  - The head pops on DOUT_VALID && DOUT_READY.
  - A capture and a pop in the same cycle are legal; count is unchanged and the new data goes behind the remaining entry.
- Latency: with an idle reader and DOUT_READY=1, a WPTR_GRAY increment first sampled at edge 0 gives DOUT_VALID=1 after edge SYNC_STAGES+2 (edge 4 at default).
- Throughput: 1 word/cycle sustained while LEVEL>0 and DOUT_READY=1.
- Backpressure:
  - With DOUT_READY=0, at most 2 words leave the SRAM.
  - DOUT holds stable while VALID&&!READY.
  - No word is ever dropped or duplicated.
- Frame counter:
  - Counts handshakes from 0 to FRAME_WORDS-1, then wraps to 0.
  - DOUT_LAST=1 on the head word when its count equals FRAME_WORDS-1.
  - Not reset by EMPTY.
- FLUSH (single-cycle or held):
  - At the edge it is sampled: rbin <= wbin, skid buffer emptied, in-flight read discarded (RD ignored next cycle), frame counter 0, DOUT_VALID=0.
  - FLUSH has priority over issue and over handshake in the same cycle; a handshake coincident with FLUSH does not count.
- Full/overrun is the writer's responsibility; this block never advances rbin past wbin.
- Reset asserted mid-stream returns all state to reset values immediately. The writer must also be reset so the pointers stay consistent.

Decomposition:
- Package tpsram_reader_pkg holds:
  - ADDR_W, DATA_W, PTR_W = ADDR_W+1.
  - Functions bin2gray and gray2bin.
- Sub-module tpsram_gray_sync: SYNC_STAGES-deep flop chain plus gray2bin. Reused on the write side for RPTR_GRAY.
- The skid buffer, issue logic and frame counter stay in the top module.

Test Plan:
- Reset, then step WPTR_GRAY through gray(1)..gray(4) one word per cycle, SRAM preloaded with 0xA0000000+addr, DOUT_READY=1:
  - DOUT = 0xA0000000..0xA0000003 on consecutive cycles.
  - First DOUT_VALID after edge 4.
  - EMPTY=1 and LEVEL=0 afterwards.
- Writer fills 10 words; DOUT_READY=0 for 20 cycles, then 1:
  - Only 2 reads issued during the stall (RADDR stops at 2, LEVEL=8).
  - DOUT holds 0xA0000000.
  - All 10 words then delivered in order with no gaps.
- Pointer wrap: rbin starts at 1020, 8 words written:
  - RADDR sequence 508,509,510,511,0,1,2,3.
  - RPTR_GRAY ends at gray(4).
  - Data in order.
- FRAME_WORDS=4, 10 words streamed, READY toggled 1,0,1,...:
  - DOUT_LAST high only on the 4th and 8th handshaken words.
- FLUSH asserted with 1 word buffered, 1 in flight and LEVEL=5:
  - Next cycle DOUT_VALID=0, EMPTY=1, LEVEL=0, RPTR_GRAY=gray(wbin).
  - A following write yields a word with a frame count of 0.
- RESET_N dropped asynchronously mid-burst:
  - All outputs reach reset values before the next RCLK edge.
  - After release, no stale DOUT_VALID.
